// File: rtl/mem_controller.sv
// Responder for the fetch and Memory-stage data ports: each 32-bit word access becomes
// two halfword cycles on a 16-bit asynchronous SRAM, with a one-entry fetch buffer.
`timescale 1ns/1ps

module mem_controller #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_en,
    input  logic [31:0]       if_mc_addr,
    output logic [31:0]       mc_if_data,
    input  logic              mem_mc_en,
    input  logic              mem_mc_rw,
    input  logic [31:0]       mem_mc_addr,
    input  logic [31:0]       mem_mc_data,
    output logic [31:0]       mc_mem_data,
    output logic              mc_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int         IDX_W     = ADDR_W - 1;
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
    localparam bit         WE_SHORT  = (WAIT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI
    } state_t;

    state_t state, state_next;

    logic [2:0]       cnt;
    logic             last;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mem_idx;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_data;
    logic             src_fetch;
    logic [15:0]      low_half;
    logic [IDX_W-1:0] fb_addr;
    logic             fb_valid;
    logic             fetch_req;
    logic             unused_addr_bits;

    // Byte-offset and out-of-range upper address bits carry no meaning here.
    assign if_idx           = if_mc_addr[ADDR_W:2];
    assign mem_idx          = mem_mc_addr[ADDR_W:2];
    assign unused_addr_bits = ^{if_mc_addr[31:ADDR_W+1], if_mc_addr[1:0],
                                mem_mc_addr[31:ADDR_W+1], mem_mc_addr[1:0]};

    assign fetch_req = if_mc_en & ~(fb_valid & (if_idx == fb_addr));
    assign last      = (cnt == 3'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_mc_en) begin
                    state_next = mem_mc_rw ? WR_LO : RD_LO;
                end else if (fetch_req) begin
                    state_next = RD_LO;
                end
            end
            RD_LO:   if (last) state_next = RD_HI;
            RD_HI:   if (last) state_next = IDLE;
            WR_LO:   if (last) state_next = WR_HI;
            WR_HI:   if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The write strobe releases one cycle early when waits exist, giving address and
    // data hold margin; with no waits the strobe covers the single cycle.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            RD_LO, RD_HI: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            WR_LO, WR_HI: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = last & WE_SHORT;
            end
            default: ;
        endcase
        sram_ub_n = sram_ce_n;
        sram_lb_n = sram_ce_n;
        mc_stall  = (state != IDLE) | mem_mc_en | fetch_req;
    end

    // Request latching, halfword sequencing and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt         <= 3'd0;
            acc_idx     <= '0;
            acc_data    <= '0;
            src_fetch   <= 1'b0;
            low_half    <= '0;
            fb_addr     <= '0;
            fb_valid    <= 1'b0;
            mc_if_data  <= '0;
            mc_mem_data <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_mc_en) begin
                        acc_idx   <= mem_idx;
                        acc_data  <= mem_mc_data;
                        src_fetch <= 1'b0;
                        cnt       <= WAIT_LOAD;
                        sram_addr <= {mem_idx, 1'b0};
                        if (mem_mc_rw) begin
                            sram_dq_out <= mem_mc_data[15:0];
                        end
                    end else if (fetch_req) begin
                        acc_idx   <= if_idx;
                        src_fetch <= 1'b1;
                        cnt       <= WAIT_LOAD;
                        sram_addr <= {if_idx, 1'b0};
                    end
                end
                RD_LO: begin
                    if (last) begin
                        low_half  <= sram_dq_in;
                        cnt       <= WAIT_LOAD;
                        sram_addr <= {acc_idx, 1'b1};
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RD_HI: begin
                    if (last) begin
                        if (src_fetch) begin
                            mc_if_data <= {sram_dq_in, low_half};
                            fb_addr    <= acc_idx;
                            fb_valid   <= 1'b1;
                        end else begin
                            mc_mem_data <= {sram_dq_in, low_half};
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WR_LO: begin
                    if (last) begin
                        sram_dq_out <= acc_data[31:16];
                        cnt         <= WAIT_LOAD;
                        sram_addr   <= {acc_idx, 1'b1};
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WR_HI: begin
                    if (last) begin
                        // A store over the buffered word must force a refetch.
                        if (fb_valid && (acc_idx == fb_addr)) begin
                            fb_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: table vectors, reset/priority sequences, randomized traffic
// against a word-level reference model, and a WAIT_CYCLES=2 instance.
`timescale 1ns/1ps

module tb_mem_controller;

    localparam int T0 = 3;  // cycles per word access with no waits: IDLE + two halfwords
    localparam int T2 = 7;  // same with WAIT_CYCLES=2

    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          fen;
        logic [31:0] faddr;
        int          exp_stall;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic [17:0] addr;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
        logic        dq_oe;
        logic [15:0] dq;
    } cyc_t;

    logic        clock, reset;
    logic        if_mc_en, mem_mc_en, mem_mc_rw;
    logic [31:0] if_mc_addr, mem_mc_addr, mem_mc_data, mc_if_data, mc_mem_data;
    logic        mc_stall, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        w_if_mc_en, w_mem_mc_en, w_mem_mc_rw;
    logic [31:0] w_if_mc_addr, w_mem_mc_addr, w_mem_mc_data, w_mc_if_data, w_mc_mem_data;
    logic        w_mc_stall, w_sram_dq_oe, w_sram_ce_n, w_sram_oe_n, w_sram_we_n;
    logic        w_sram_ub_n, w_sram_lb_n;
    logic [17:0] w_sram_addr;
    logic [15:0] w_sram_dq_out, w_sram_dq_in;

    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] sram0 [0:511];
    logic [15:0] sram_w [0:511];

    cyc_t trace0[$];
    cyc_t trace_w[$];

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [0:255];
    bit          fb_v;
    logic [7:0]  fb_i;
    logic [31:0] exp_if_m, exp_mem_m;

    mem_controller #(.ADDR_W(18), .WAIT_CYCLES(0)) dut (
        .clock(clock), .reset(reset),
        .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr), .mc_if_data(mc_if_data),
        .mem_mc_en(mem_mc_en), .mem_mc_rw(mem_mc_rw), .mem_mc_addr(mem_mc_addr),
        .mem_mc_data(mem_mc_data), .mc_mem_data(mc_mem_data), .mc_stall(mc_stall),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    mem_controller #(.ADDR_W(18), .WAIT_CYCLES(2)) dut_w (
        .clock(clock), .reset(reset),
        .if_mc_en(w_if_mc_en), .if_mc_addr(w_if_mc_addr), .mc_if_data(w_mc_if_data),
        .mem_mc_en(w_mem_mc_en), .mem_mc_rw(w_mem_mc_rw), .mem_mc_addr(w_mem_mc_addr),
        .mem_mc_data(w_mem_mc_data), .mc_mem_data(w_mc_mem_data), .mc_stall(w_mc_stall),
        .sram_addr(w_sram_addr), .sram_dq_out(w_sram_dq_out), .sram_dq_oe(w_sram_dq_oe),
        .sram_dq_in(w_sram_dq_in), .sram_ce_n(w_sram_ce_n), .sram_oe_n(w_sram_oe_n),
        .sram_we_n(w_sram_we_n), .sram_ub_n(w_sram_ub_n), .sram_lb_n(w_sram_lb_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Asynchronous SRAM models: combinational read, write committed while we_n is low.
    assign sram_dq_in   = (!sram_ce_n && !sram_oe_n) ? sram0[sram_addr[8:0]] : 16'h0000;
    assign w_sram_dq_in = (!w_sram_ce_n && !w_sram_oe_n) ? sram_w[w_sram_addr[8:0]] : 16'h0000;

    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n) sram0[sram_addr[8:0]] <= sram_dq_out;
        else if (pl_en) sram0[pl_addr] <= pl_data;
    end

    always @(posedge clock) begin
        if (!w_sram_ce_n && !w_sram_we_n) sram_w[w_sram_addr[8:0]] <= w_sram_dq_out;
        else if (pl_en) sram_w[pl_addr] <= pl_data;
    end

    always @(negedge clock) begin
        if (!sram_ce_n)
            trace0.push_back('{sram_addr, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                               sram_dq_oe, sram_dq_out});
        if (!w_sram_ce_n)
            trace_w.push_back('{w_sram_addr, w_sram_oe_n, w_sram_we_n, w_sram_ub_n, w_sram_lb_n,
                                w_sram_dq_oe, w_sram_dq_out});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Counts cycles with stall high; the data request is a one-cycle pulse.
    task automatic wait_idle(input bit w, output int cycles);
        cycles = 0;
        @(negedge clock);
        while ((w ? w_mc_stall : mc_stall) && cycles < 200) begin
            cycles++;
            @(posedge clock);
            #1;
            if (w) w_mem_mc_en = 1'b0;
            else   mem_mc_en   = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic drive(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit fen, input logic [31:0] faddr, output int cyc);
        @(posedge clock);
        #1;
        if_mc_en    = fen;
        if_mc_addr  = faddr;
        mem_mc_en   = (op != OP_NONE);
        mem_mc_rw   = (op == OP_WRITE);
        mem_mc_addr = addr;
        mem_mc_data = wdata;
        wait_idle(1'b0, cyc);
    endtask

    // Word-level model: data request first, then a fetch if the buffer misses.
    task automatic model_op(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit fen, input logic [31:0] faddr, output int cyc);
        logic [7:0] di, fi;
        di  = addr[9:2];
        fi  = faddr[9:2];
        cyc = 0;
        if (op != OP_NONE) begin
            cyc += T0;
            if (op == OP_WRITE) begin
                ref_mem[di] = wdata;
                if (fb_v && fb_i == di) fb_v = 1'b0;
            end else begin
                exp_mem_m = ref_mem[di];
            end
        end
        if (fen && !(fb_v && fb_i == fi)) begin
            cyc      += T0;
            fb_v      = 1'b1;
            fb_i      = fi;
            exp_if_m  = ref_mem[fi];
        end
    endtask

    initial begin
        vec_t        tbl [9];
        int          cyc, mcyc, exp_tr [6], nwe, ndq;
        cyc_t        wq[$];
        op_e         op;
        logic [31:0] a, d, fa;
        bit          fen;

        reset = 1'b0;
        if_mc_en = 0; if_mc_addr = 0; mem_mc_en = 0; mem_mc_rw = 0; mem_mc_addr = 0; mem_mc_data = 0;
        w_if_mc_en = 0; w_if_mc_addr = 0; w_mem_mc_en = 0; w_mem_mc_rw = 0;
        w_mem_mc_addr = 0; w_mem_mc_data = 0;
        pl_en = 0; pl_addr = 0; pl_data = 0;
        fb_v = 0; fb_i = 0; exp_if_m = 0; exp_mem_m = 0;

        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h2408_0000;
        ref_mem[1] = 32'h1111_2222;
        ref_mem[2] = 32'h3333_4444;
        ref_mem[4] = 32'h5555_6666;
        ref_mem[8] = 32'h7777_8888;

        tbl[0] = '{OP_NONE,  32'h0,         32'h0,         1, 32'h00, 3, 32'h2408_0000, 32'h0};
        tbl[1] = '{OP_NONE,  32'h0,         32'h0,         1, 32'h04, 3, 32'h1111_2222, 32'h0};
        tbl[2] = '{OP_NONE,  32'h0,         32'h0,         1, 32'h08, 3, 32'h3333_4444, 32'h0};
        tbl[3] = '{OP_NONE,  32'h0,         32'h0,         1, 32'h04, 3, 32'h1111_2222, 32'h0};
        tbl[4] = '{OP_NONE,  32'h0,         32'h0,         1, 32'h04, 0, 32'h1111_2222, 32'h0};
        tbl[5] = '{OP_WRITE, 32'h4,         32'hDEAD_BEEF, 1, 32'h04, 6, 32'hDEAD_BEEF, 32'h0};
        tbl[6] = '{OP_READ,  32'h10,        32'h0,         1, 32'h20, 6, 32'h7777_8888, 32'h5555_6666};
        tbl[7] = '{OP_READ,  32'hFFF8_0013, 32'h0,         1, 32'h20, 3, 32'h7777_8888, 32'h5555_6666};
        tbl[8] = '{OP_READ,  32'h4,         32'h0,         1, 32'h20, 3, 32'h7777_8888, 32'hDEAD_BEEF};
        exp_tr = '{2, 3, 4, 5, 2, 3};

        // Preload both SRAMs while the controllers are held in reset.
        for (int i = 0; i < 512; i++) begin
            @(posedge clock);
            #1;
            pl_en   = 1'b1;
            pl_addr = i[8:0];
            pl_data = i[0] ? ref_mem[i >> 1][31:16] : ref_mem[i >> 1][15:0];
        end
        @(posedge clock);
        #1;
        pl_en = 1'b0;

        check("rst if_data", mc_if_data, 32'h0);
        check("rst mem_data", mc_mem_data, 32'h0);
        check("rst sram_addr", 32'(sram_addr), 32'h0);
        check("rst ctl", {26'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
              32'b111110);
        check("rst stall", 32'(mc_stall), 32'h0);
        check("rst w ctl", {29'h0, w_sram_ce_n, w_sram_we_n, w_sram_dq_oe}, 32'b110);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (i == 1 || i == 5) trace0.delete();
            drive(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].fen, tbl[i].faddr, cyc);
            model_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].fen, tbl[i].faddr, mcyc);
            check($sformatf("vec%0d stall", i), cyc, tbl[i].exp_stall);
            check($sformatf("vec%0d if_data", i), mc_if_data, tbl[i].exp_if);
            check($sformatf("vec%0d mem_data", i), mc_mem_data, tbl[i].exp_mem);
            if (i == 3) begin
                check("fetch trace len", trace0.size(), 6);
                for (int k = 0; k < 6 && k < trace0.size(); k++)
                    check($sformatf("fetch trace %0d", k), 32'(trace0[k].addr), exp_tr[k]);
            end
            if (i == 5) begin
                wq.delete();
                foreach (trace0[k]) if (!trace0[k].we_n) wq.push_back(trace0[k]);
                check("wr strobes", wq.size(), 2);
                if (wq.size() == 2) begin
                    check("wr lo", {wq[0].addr[15:0], wq[0].dq}, 32'h0002_BEEF);
                    check("wr hi", {wq[1].addr[15:0], wq[1].dq}, 32'h0003_DEAD);
                end
            end
        end

        // Reset pulsed while a fetch is in its high-halfword read.
        @(posedge clock);
        #1;
        if_mc_addr = 32'h8;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rd_hi addr", 32'(sram_addr), 32'h5);
        check("rd_hi oe_n", 32'(sram_oe_n), 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst if_data", mc_if_data, 32'h0);
        check("midrst mem_data", mc_mem_data, 32'h0);
        check("midrst sram_addr", 32'(sram_addr), 32'h0);
        check("midrst dq_out", 32'(sram_dq_out), 32'h0);
        check("midrst ctl", {26'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
              32'b111110);
        reset = 1'b1;
        fb_v = 1'b0; exp_if_m = 32'h0; exp_mem_m = 32'h0;
        wait_idle(1'b0, cyc);
        model_op(OP_NONE, 32'h0, 32'h0, 1'b1, 32'h8, mcyc);
        check("refetch stall", cyc, mcyc);
        check("refetch data", mc_if_data, exp_if_m);

        // Randomized traffic: small address sets so hits, misses and invalidations mix.
        for (int n = 0; n < 120; n++) begin
            op  = op_e'($urandom_range(0, 2));
            a   = ($urandom & 32'hFFF8_0003) | ($urandom_range(0, 15) << 2);
            d   = $urandom;
            fen = ($urandom_range(0, 3) != 0);
            fa  = ($urandom & 32'hFFF8_0003) | ($urandom_range(0, 7) << 2);
            drive(op, a, d, fen, fa, cyc);
            model_op(op, a, d, fen, fa, mcyc);
            check($sformatf("rnd%0d stall", n), cyc, mcyc);
            check($sformatf("rnd%0d if_data", n), mc_if_data, exp_if_m);
            check($sformatf("rnd%0d mem_data", n), mc_mem_data, exp_mem_m);
        end

        // WAIT_CYCLES=2 instance: fetch word 0, store to word 1, read it back.
        trace_w.delete();
        @(posedge clock);
        #1;
        w_if_mc_en = 1'b1; w_if_mc_addr = 32'h0;
        wait_idle(1'b1, cyc);
        check("w2 fetch stall", cyc, T2);
        check("w2 fetch data", w_mc_if_data, 32'h2408_0000);
        check("w2 read trace len", trace_w.size(), 6);
        foreach (trace_w[k]) begin
            check($sformatf("w2 rd addr %0d", k), 32'(trace_w[k].addr), (k < 3) ? 0 : 1);
            check($sformatf("w2 rd lanes %0d", k), {30'h0, trace_w[k].ub_n, trace_w[k].lb_n}, 32'h0);
        end

        trace_w.delete();
        @(posedge clock);
        #1;
        w_mem_mc_en = 1'b1; w_mem_mc_rw = 1'b1; w_mem_mc_addr = 32'h4; w_mem_mc_data = 32'hCAFE_F00D;
        wait_idle(1'b1, cyc);
        check("w2 write stall", cyc, T2);
        check("w2 write trace len", trace_w.size(), 6);
        wq.delete();
        ndq = 0;
        foreach (trace_w[k]) begin
            if (!trace_w[k].we_n) wq.push_back(trace_w[k]);
            if (trace_w[k].dq_oe) ndq++;
        end
        nwe = wq.size();
        check("w2 we_n low cycles", nwe, 4);
        check("w2 dq_oe cycles", ndq, 6);
        foreach (wq[k])
            check($sformatf("w2 strobe %0d", k), {wq[k].addr[15:0], wq[k].dq},
                  (k < 2) ? 32'h0002_F00D : 32'h0003_CAFE);

        @(posedge clock);
        #1;
        w_mem_mc_en = 1'b1; w_mem_mc_rw = 1'b0; w_mem_mc_addr = 32'h4;
        wait_idle(1'b1, cyc);
        check("w2 read stall", cyc, T2);
        check("w2 read data", w_mc_mem_data, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
